// File: rtl/bram_port_arbiter_if.sv
// Client-side and BRAM-side signal bundle for bram_port_arbiter.
// master = arbiter view, slave = clients/BRAM view.
interface bram_port_arbiter_if #(
  parameter int Width      = 8,
  parameter int AddrWidth  = 8,
  parameter int NumClients = 2
);
  localparam int ReqWidth = Width + AddrWidth + 1;

  logic [NumClients-1:0][ReqWidth-1:0] client_reqs;
  logic [NumClients-1:0]               client_req_valids;
  logic [NumClients-1:0]               client_req_bps;
  logic [NumClients-1:0][Width-1:0]    client_resps;
  logic [NumClients-1:0]               client_resp_valids;
  logic [NumClients-1:0]               client_resp_bps;

  logic [ReqWidth-1:0]                 mem_req;
  logic                                mem_req_valid;
  logic                                mem_req_bp;
  logic [Width-1:0]                    mem_resp;
  logic                                mem_resp_valid;
  logic                                mem_resp_bp;

  modport master (
    input  client_reqs, client_req_valids, client_resp_bps,
    output client_req_bps, client_resps, client_resp_valids,
    output mem_req, mem_req_valid, mem_resp_bp,
    input  mem_req_bp, mem_resp, mem_resp_valid
  );

  modport slave (
    output client_reqs, client_req_valids, client_resp_bps,
    input  client_req_bps, client_resps, client_resp_valids,
    input  mem_req, mem_req_valid, mem_resp_bp,
    output mem_req_bp, mem_resp, mem_resp_valid
  );
endinterface

// File: rtl/bram_port_arbiter.sv
// Round-robin merge of NumClients request streams onto one BRAM port; optional perf counters via BRAM_ARB_PERF_EN.
// Latency: accepted request presented to the BRAM the next cycle; response routed back combinationally.
// Backpressure: one-entry pipelined hold stage; a stalled response of the held client stalls every client.
module bram_port_arbiter #(
  parameter string Name            = "",
  parameter int    Width           = 8,
  parameter int    AddrWidth       = 8,
  parameter int    NumClients      = 2,
  parameter int    CLog2NumClients = 1
) (
  input  logic        clk,
  input  logic        resetn,
`ifdef BRAM_ARB_PERF_EN
  output logic [31:0] stall_count,
  output logic [31:0] grant_count,
`endif
  bram_port_arbiter_if.master bus
);

  typedef struct packed {
    logic [AddrWidth-1:0] addr;
    logic [Width-1:0]     data;
    logic                 wr;
  } req_t;

  req_t                       hold_req;
  logic                       hold_valid;
  logic [CLog2NumClients-1:0] hold_id;
  logic [CLog2NumClients-1:0] rr_ptr;

  logic [CLog2NumClients-1:0] grant_id;
  logic [CLog2NumClients-1:0] rr_next;
  logic                       grant_found;
  logic                       fire;
  logic                       load_en;
  logic                       accept;

  assign fire    = hold_valid & ~bus.mem_req_bp;
  assign load_en = ~hold_valid | fire;

  // Scan from rr_ptr upward, wrapping at NumClients (not at a power of two).
  always_comb begin
    int                         idx;
    logic [CLog2NumClients-1:0] sel;
    grant_found = 1'b0;
    grant_id    = '0;
    idx         = 0;
    sel         = '0;
    for (int k = 0; k < NumClients; k++) begin
      idx = int'(rr_ptr) + k;
      if (idx >= NumClients) idx = idx - NumClients;
      sel = CLog2NumClients'(idx);
      if (!grant_found && bus.client_req_valids[sel]) begin
        grant_found = 1'b1;
        grant_id    = sel;
      end
    end
  end

  assign rr_next = (grant_id == CLog2NumClients'(NumClients - 1)) ? '0
                                                                  : grant_id + CLog2NumClients'(1);

  // Gated by resetn so every client sees backpressure while reset is held.
  assign accept = resetn & load_en & grant_found;

  always_comb begin
    for (int k = 0; k < NumClients; k++) begin
      bus.client_req_bps[k]     = ~(accept && (grant_id == CLog2NumClients'(k)));
      bus.client_resps[k]       = bus.mem_resp;
      bus.client_resp_valids[k] = bus.mem_resp_valid & hold_valid &
                                  (hold_id == CLog2NumClients'(k));
    end
  end

  assign bus.mem_req       = hold_req;
  assign bus.mem_req_valid = hold_valid;
  assign bus.mem_resp_bp   = hold_valid ? bus.client_resp_bps[hold_id] : 1'b0;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      hold_valid <= 1'b0;
      hold_req   <= '0;
      hold_id    <= '0;
      rr_ptr     <= '0;
    end else if (accept) begin
      hold_valid <= 1'b1;
      hold_req   <= req_t'(bus.client_reqs[grant_id]);
      hold_id    <= grant_id;
      rr_ptr     <= rr_next;
    end else if (fire) begin
      hold_valid <= 1'b0;
    end
  end

`ifdef BRAM_ARB_PERF_EN
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      stall_count <= '0;
      grant_count <= '0;
    end else begin
      if (hold_valid && bus.mem_req_bp && (stall_count != '1))
        stall_count <= stall_count + 32'd1;
      if (accept && (grant_count != '1))
        grant_count <= grant_count + 32'd1;
    end
  end
`endif

  always @(posedge clk) begin
    if (resetn && hold_valid)
      assert (int'(hold_id) < NumClients)
        else $error("%s: hold_id %0d out of range", Name, hold_id);
  end

endmodule
